// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake and stored carry
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  input  logic             flag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzvc,
  output logic             carry_q
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_INC = 4'd1,  OP_SUB = 4'd2,  OP_DEC = 4'd3,
    OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7,
    OP_ADC = 4'd8,  OP_SBC = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11,
    OP_ASR = 4'd12, OP_ROL = 4'd13, OP_ROR = 4'd14, OP_CMP = 4'd15
  } op_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             accept;
  logic             cin;
  logic [WIDTH-1:0] add_opb;
  logic [WIDTH-1:0] sub_opb;
  logic             add_cin;
  logic             sub_cin;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_v;
  logic             sub_v;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] flag_val;
  logic             v_c;
  logic             c_c;

  // Single output slot: accept only when the slot is empty or draining this cycle.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  // A same-cycle clear means the op must see carry-in 0.
  assign cin      = flag_clr ? 1'b0 : carry_q;

  // Shared adder and subtractor; INC/DEC reuse them with a constant 1 operand.
  always_comb begin
    add_opb  = (alu_sel == OP_INC) ? ONE : b;
    sub_opb  = (alu_sel == OP_DEC) ? ONE : b;
    add_cin  = (alu_sel == OP_ADC) ? cin : 1'b0;
    sub_cin  = (alu_sel == OP_SBC) ? cin : 1'b0;
    add_full = {1'b0, a} + {1'b0, add_opb} + {{WIDTH{1'b0}}, add_cin};
    sub_full = {1'b0, a} - {1'b0, sub_opb} - {{WIDTH{1'b0}}, sub_cin};
    add_v    = (a[WIDTH-1] == add_opb[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
    sub_v    = (a[WIDTH-1] != sub_opb[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
  end

  // Opcode decode: result value, the value N/Z are taken from, and V/C.
  always_comb begin
    res_c    = '0;
    flag_val = '0;
    v_c      = 1'b0;
    c_c      = 1'b0;
    case (op_e'(alu_sel))
      OP_ADD, OP_INC, OP_ADC: begin
        res_c = add_full[WIDTH-1:0];
        v_c   = add_v;
        c_c   = add_full[WIDTH];
      end
      OP_SUB, OP_DEC, OP_SBC: begin
        res_c = sub_full[WIDTH-1:0];
        v_c   = sub_v;
        c_c   = sub_full[WIDTH];
      end
      OP_CMP: begin
        res_c    = a;
        flag_val = sub_full[WIDTH-1:0];
        v_c      = sub_v;
        c_c      = sub_full[WIDTH];
      end
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_XOR: res_c = a ^ b;
      OP_NOT: res_c = ~a;
      OP_SHL: begin
        res_c = {a[WIDTH-2:0], 1'b0};
        c_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        res_c = {1'b0, a[WIDTH-1:1]};
        c_c   = a[0];
      end
      OP_ASR: begin
        res_c = {a[WIDTH-1], a[WIDTH-1:1]};
        c_c   = a[0];
      end
      OP_ROL: begin
        res_c = {a[WIDTH-2:0], a[WIDTH-1]};
        c_c   = a[WIDTH-1];
      end
      OP_ROR: begin
        res_c = {a[0], a[WIDTH-1:1]};
        c_c   = a[0];
      end
      default: res_c = '0;
    endcase
    if (alu_sel != OP_CMP) flag_val = res_c;
  end

  // Output slot and stored carry; everything holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      nzvc      <= 4'b0000;
      carry_q   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= res_c;
      nzvc      <= {flag_val[WIDTH-1], (flag_val == '0), v_c, c_c};
      carry_q   <= c_c;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (flag_clr) carry_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [3:0]  sel8 = '0;
  logic        fc8 = 1'b0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  result8;
  logic [3:0]  nzvc8;
  logic        carry8;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic [3:0]  sel16 = '0;
  logic        fc16 = 1'b0;
  logic        out_valid16;
  logic        out_ready16 = 1'b1;
  logic [15:0] result16;
  logic [3:0]  nzvc16;
  logic        carry16;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .alu_sel(sel8), .flag_clr(fc8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .nzvc(nzvc8), .carry_q(carry8)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .alu_sel(sel16), .flag_clr(fc16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .nzvc(nzvc16), .carry_q(carry16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid8 && out_ready8) hs_cnt = hs_cnt + 1;
  end

  task automatic issue8(input logic [3:0] sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic fc);
    @(negedge clk);
    in_valid8 = 1'b1; sel8 = sel; a8 = av; b8 = bv; fc8 = fc;
    @(posedge clk); #1;
    in_valid8 = 1'b0; fc8 = 1'b0;
  endtask

  task automatic expect8(input string name, input logic [7:0] er, input logic [3:0] ef,
                         input logic ec);
    checks++;
    if (out_valid8 !== 1'b1 || result8 !== er || nzvc8 !== ef || carry8 !== ec) begin
      errors++;
      $display("FAIL %s: got v=%b res=%h nzvc=%b c=%b, want v=1 res=%h nzvc=%b c=%b",
               name, out_valid8, result8, nzvc8, carry8, er, ef, ec);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (out_valid8 !== 1'b0 || result8 !== 8'h00 || nzvc8 !== 4'b0000 || carry8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b res=%h nzvc=%b c=%b, want 0", out_valid8, result8,
               nzvc8, carry8);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 1'b1 || in_ready16 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready8, in_ready16);
    end
  endtask

  task automatic test_add;
    issue8(4'd0, 8'd100, 8'd30, 1'b0);
    expect8("add_100_30", 8'h82, 4'b1010, 1'b0);
    issue8(4'd0, 8'd100, 8'h88, 1'b0);
    expect8("add_100_m120", 8'hEC, 4'b1000, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL drain: out_valid=%b want 0", out_valid8);
    end
  endtask

  task automatic test_inc_adc;
    issue8(4'd1, 8'h7F, 8'h00, 1'b0);
    expect8("inc_7f", 8'h80, 4'b1010, 1'b0);
    issue8(4'd1, 8'hFF, 8'h00, 1'b0);
    expect8("inc_ff", 8'h00, 4'b0101, 1'b1);
    issue8(4'd8, 8'd1, 8'd5, 1'b0);
    expect8("adc_1_5_c1", 8'h07, 4'b0000, 1'b0);
  endtask

  task automatic test_sub_cmp;
    issue8(4'd2, 8'd17, 8'd40, 1'b0);
    expect8("sub_17_40", 8'hE9, 4'b1001, 1'b1);
    issue8(4'd3, 8'h80, 8'h00, 1'b0);
    expect8("dec_80", 8'h7F, 4'b0010, 1'b0);
    issue8(4'd15, 8'd73, 8'd73, 1'b0);
    expect8("cmp_73_73", 8'h49, 4'b0100, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [3:0] vs [9];
    logic [7:0] va [9];
    logic [7:0] vb [9];
    logic [7:0] vr [9];
    logic [3:0] vf [9];
    int hs0;
    vs = '{4'd0, 4'd6, 4'd4, 4'd5, 4'd7, 4'd11, 4'd12, 4'd10, 4'd14};
    va = '{8'h01, 8'hF0, 8'hF0, 8'h0F, 8'h00, 8'h03, 8'h81, 8'h80, 8'h01};
    vb = '{8'h02, 8'h3C, 8'h3C, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vr = '{8'h03, 8'hCC, 8'h30, 8'h3F, 8'hFF, 8'h01, 8'hC0, 8'h00, 8'h80};
    vf = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b0101, 4'b1001};
    // stall with the CMP result still held in the slot
    @(negedge clk);
    out_ready8 = 1'b0;
    in_valid8 = 1'b1; sel8 = vs[0]; a8 = va[0]; b8 = vb[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1 || result8 !== 8'h49 ||
          nzvc8 !== 4'b0100 || carry8 !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: rdy=%b v=%b res=%h nzvc=%b c=%b, want 0 1 49 0100 0",
                 i, in_ready8, out_valid8, result8, nzvc8, carry8);
      end
    end
    @(negedge clk);
    hs0 = hs_cnt;
    out_ready8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sel8 = vs[i]; a8 = va[i]; b8 = vb[i];
      @(posedge clk); #1;
      checks++;
      if (out_valid8 !== 1'b1 || result8 !== vr[i] || nzvc8 !== vf[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: v=%b res=%h nzvc=%b, want 1 %h %b", i, out_valid8, result8,
                 nzvc8, vr[i], vf[i]);
      end
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid8 !== 1'b0 || hs_cnt - hs0 !== 10 || carry8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: v=%b handshakes=%0d carry=%b, want 0 10 1", out_valid8,
               hs_cnt - hs0, carry8);
    end
  endtask

  task automatic test_flag_clr;
    issue8(4'd1, 8'hFF, 8'h00, 1'b0);
    expect8("set_carry_a", 8'h00, 4'b0101, 1'b1);
    issue8(4'd9, 8'd10, 8'd3, 1'b1);
    expect8("sbc_clr", 8'h07, 4'b0000, 1'b0);
    issue8(4'd1, 8'hFF, 8'h00, 1'b0);
    issue8(4'd9, 8'd10, 8'd3, 1'b0);
    expect8("sbc_cin1", 8'h06, 4'b0000, 1'b0);
    issue8(4'd1, 8'hFF, 8'h00, 1'b0);
    @(negedge clk);
    fc8 = 1'b1;
    @(posedge clk); #1;
    fc8 = 1'b0;
    checks++;
    if (carry8 !== 1'b0) begin
      errors++;
      $display("FAIL flag_clr_idle: carry=%b want 0", carry8);
    end
  endtask

  task automatic test_reset_mid_stall;
    issue8(4'd0, 8'hFF, 8'h02, 1'b0);
    out_ready8 = 1'b0;
    expect8("pre_reset", 8'h01, 4'b0001, 1'b1);
    @(negedge clk); @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid8 !== 1'b0 || result8 !== 8'h00 || nzvc8 !== 4'b0000 || carry8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: v=%b res=%h nzvc=%b c=%b, want 0", out_valid8, result8,
               nzvc8, carry8);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready8 = 1'b1;
  endtask

  task automatic test_width16;
    @(negedge clk);
    in_valid16 = 1'b1; sel16 = 4'd13; a16 = 16'h0081; b16 = 16'h0000;
    @(posedge clk); #1;
    checks++;
    if (out_valid16 !== 1'b1 || result16 !== 16'h0102 || nzvc16 !== 4'b0000) begin
      errors++;
      $display("FAIL rol16_0081: v=%b res=%h nzvc=%b, want 1 0102 0000", out_valid16,
               result16, nzvc16);
    end
    @(negedge clk);
    a16 = 16'h8001;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    checks++;
    if (result16 !== 16'h0003 || nzvc16 !== 4'b0001 || carry16 !== 1'b1) begin
      errors++;
      $display("FAIL rol16_8001: res=%h nzvc=%b c=%b, want 0003 0001 1", result16, nzvc16,
               carry16);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_inc_adc;
    test_sub_cmp;
    test_back_to_back;
    test_flag_clr;
    test_reset_mid_stall;
    test_width16;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the 8-bit combinational ALU (alub). Same NZVC flag semantics and the same opcode encoding for ops 0-7. Adds:
- WIDTH generalisation
- a valid/ready handshake on input and output
- a 1-cycle registered result
- a stored carry flag feeding new ADC/SBC ops
- shift, rotate and compare ops

It sits between the register-file read stage and the writeback stage of the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept an operand this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored by unary ops)
- alu_sel  in  4  opcode
- flag_clr  in  1  synchronous clear of the stored carry
- out_valid  out  1  result/nzvc valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- nzvc  out  4  registered flags {N,Z,V,C}
- carry_q  out  1  stored carry used by ADC/SBC

Behaviour:
- Reset (async, rst=1): out_valid=0, result=0, nzvc=0, carry_q=0. in_ready=1 once rst deasserts. Reset asserted mid-operation drops any held result with no handshake.
- in_ready = !out_valid | out_ready (combinational; single output slot, no skid buffer).
- Accept = in_valid & in_ready. On accept, result/nzvc load the computed values and out_valid<=1. Latency is 1 cycle.
- If out_valid & out_ready & !accept, then out_valid<=0.
- While out_valid & !out_ready (stall): result, nzvc and carry_q hold, and in_ready=0.
- On accept, carry_q <= new C. If flag_clr is set and no accept occurs, carry_q <= 0.
- If flag_clr and accept occur in the same cycle, the op sees carry-in 0, then carry_q <= the op's C.
- Opcodes. Arithmetic is modulo 2^WIDTH; cin denotes carry_q, or 0 when flag_clr=1.
  - 0 ADD: A+B
  - 1 INC: A+1
  - 2 SUB: A-B
  - 3 DEC: A-1
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOT: ~A
  - 8 ADC: A+B+cin
  - 9 SBC: A-B-cin
  - 10 SHL: A<<1
  - 11 SHR: logical A>>1
  - 12 ASR: arithmetic A>>>1
  - 13 ROL: rotate left by 1
  - 14 ROR: rotate right by 1
  - 15 CMP: flags as SUB, result = A unchanged
- Flags (from the value loaded into result, or from the A-B difference for CMP):
  - N = MSB.
  - Z = (value == 0).
  - Add-type ops (ADD, INC, ADC): C = carry out of bit WIDTH-1. V = both operands have the same sign and the sum has a different sign (INC treats its second operand as +1).
  - Subtract-type ops (SUB, DEC, SBC, CMP): C = borrow, i.e. unsigned A < subtrahend (+cin for SBC). V = operands have different signs and the result sign differs from A.
  - AND/OR/XOR/NOT: V=0, C=0.
  - Shifts/rotates: C = bit shifted/rotated out (SHL/ROL: A[WIDTH-1]; SHR/ASR/ROR: A[0]), V=0.
- a/b/alu_sel are only sampled on accept. Values while in_valid=0 are don't-care.
- No X may propagate to outputs after reset for any opcode.

Test Plan:
- Reset, then WIDTH=8 ADD a=100 b=30, out_ready=1 → next cycle out_valid=1, result=0x82, nzvc=1010. ADD 100 + (-120) → 0xEC, 1000.
- INC a=0x7F → 0x80, nzvc=1010. Then INC a=0xFF → 0x00, nzvc=0101, carry_q=1. Then ADC a=1 b=5 → 0x07, nzvc=0000, carry_q=0.
- SUB a=17 b=40 → 0xE9, nzvc=1001. DEC a=0x80 → 0x7F, nzvc=0010. CMP a=73 b=73 → result=0x49, nzvc=0100.
- Hold out_ready=0 with in_valid=1 for 5 cycles → in_ready=0; result/nzvc/carry_q stable. Raise out_ready → back-to-back accepts, one result per cycle, no loss or duplication.
- Set carry_q=1 (INC 0xFF). Then SBC a=10 b=3 with flag_clr=1 → 0x07 (cin=0), nzvc=0000. Repeat without flag_clr after setting carry_q=1 → 0x06.
- Assert rst mid-stall with out_valid=1 → out_valid, result, nzvc and carry_q are 0 immediately. Rerun ROL a=0x81 with WIDTH=16 → 0x0102, nzvc=0000.
